// File: rtl/scan_link_pkg.sv
// Shared types and constants for the edge-timed scan link (transmitter and receiver).
package scan_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        BIT_A,
        BIT_B,
        SCAN_WAIT,
        SCAN,
        DONE
    } state_e;

    localparam int NUM_SYNC_EDGES = 3;
    localparam int META_BITS      = 4;
    localparam int TIMER_W        = 16;
    localparam int META_IDX_W     = $clog2(META_BITS);
    localparam int SYNC_CNT_W     = $clog2(NUM_SYNC_EDGES + 1);

    // The interval timer counts down to zero, so an N-cycle gap loads N-1.
    function automatic logic [TIMER_W-1:0] reload_of(input int unsigned interval);
        return TIMER_W'(interval - 1);
    endfunction

endpackage

// File: rtl/scan_link_tx_if.sv
// Host-side bundle for scan_link_tx: request/metadata inputs, link line and status outputs.
interface scan_link_tx_if;
    import scan_link_pkg::*;

    // start is a one-cycle request, accepted only while busy is low; abort wins over start.
    logic                 start;
    logic                 abort;
    logic [META_BITS-1:0] meta;
    logic [7:0]           scan_edges;
    logic                 DATA_OUT;
    logic                 edge_strobe;
    logic                 scan_pos;
    logic                 busy;
    logic                 done;
    state_e               state_dbg;

    modport master (
        output start, abort, meta, scan_edges,
        input  DATA_OUT, edge_strobe, scan_pos, busy, done, state_dbg
    );

    modport slave (
        input  start, abort, meta, scan_edges,
        output DATA_OUT, edge_strobe, scan_pos, busy, done, state_dbg
    );

endinterface

// File: rtl/scan_link_interval_timer.sv
// Down-counting interval timer; expire_o pulses while enabled and the count sits at zero.
module scan_link_interval_timer
    import scan_link_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               expire_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/scan_link_tx.sv
// Edge-timed scan link transmitter: sync edges, start edge, ratio-coded metadata, scan edge train.
// Build option SCAN_LINK_TX_TOGGLE_EN: edges toggle the DATA_OUT level instead of pulsing it.
module scan_link_tx
    import scan_link_pkg::*;
#(
    parameter int unsigned SYNC_GAP  = 64,
    parameter int unsigned BIT_SHORT = 4,
    parameter int unsigned BIT_LONG  = 12,
    parameter int unsigned SCAN_GAP  = 32,
    parameter int unsigned SCAN_HALF = 100
) (
    input logic           CLK_IN,
    input logic           rst,
    scan_link_tx_if.slave bus
);

    state_e                  state_q;
    logic [META_BITS-1:0]    meta_q;
    logic [7:0]              scan_n_q;
    logic [7:0]              scan_cnt_q;
    logic [SYNC_CNT_W-1:0]   sync_cnt_q;
    logic [META_IDX_W-1:0]   idx_q;
    logic [META_IDX_W-1:0]   idx_nxt;
    logic                    data_q;
    logic                    strobe_q;
    logic                    scan_pos_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    expire;
    logic                    fire;
    logic                    tmr_en;
    logic                    tmr_load;
    logic [TIMER_W-1:0]      tmr_val;
    logic [TIMER_W-1:0]      reload_d;

    // First half of a bit is long for a 1, second half is the complement.
    function automatic logic [TIMER_W-1:0] bit_reload(input logic bit_val, input logic first_half);
        logic use_long;
        use_long = first_half ? bit_val : ~bit_val;
        return use_long ? reload_of(BIT_LONG) : reload_of(BIT_SHORT);
    endfunction

    assign idx_nxt = idx_q + 1'b1;

    // fire marks the cycle before an edge; the timer reloads with the interval that follows it.
    always_comb begin
        fire     = 1'b0;
        reload_d = '0;
        case (state_q)
            IDLE: begin
                fire     = bus.start;
                reload_d = reload_of(SYNC_GAP);
            end
            SYNC: begin
                fire     = expire;
                reload_d = reload_of(SYNC_GAP);
            end
            START: begin
                fire     = expire;
                reload_d = bit_reload(meta_q[0], 1'b1);
            end
            BIT_A: begin
                fire     = expire;
                reload_d = bit_reload(meta_q[idx_q], 1'b0);
            end
            BIT_B: begin
                fire     = expire;
                reload_d = (idx_q == META_IDX_W'(META_BITS - 1)) ? reload_of(SCAN_GAP)
                                                                  : bit_reload(meta_q[idx_nxt], 1'b1);
            end
            SCAN_WAIT: begin
                fire     = expire && (scan_n_q != '0);
                reload_d = reload_of(SCAN_HALF);
            end
            SCAN: begin
                fire     = expire && (scan_cnt_q != scan_n_q);
                reload_d = reload_of(SCAN_HALF);
            end
            default: begin
                fire     = 1'b0;
                reload_d = '0;
            end
        endcase
        if (bus.abort) begin
            fire = 1'b0;
        end
    end

    assign tmr_en   = (state_q != IDLE) && (state_q != DONE);
    assign tmr_load = fire || bus.abort;
    assign tmr_val  = fire ? reload_d : '0;

    scan_link_interval_timer u_timer (
        .clk_i      (CLK_IN),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expire_o   (expire)
    );

    always_ff @(posedge CLK_IN or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            meta_q     <= '0;
            scan_n_q   <= '0;
            scan_cnt_q <= '0;
            sync_cnt_q <= '0;
            idx_q      <= '0;
            data_q     <= 1'b0;
            strobe_q   <= 1'b0;
            scan_pos_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            strobe_q <= fire;
`ifdef SCAN_LINK_TX_TOGGLE_EN
            data_q   <= data_q ^ fire;
`else
            data_q   <= fire;
`endif
            done_q   <= 1'b0;
            if (bus.abort && (state_q != IDLE)) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                scan_pos_q <= 1'b0;
                data_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fire) begin
                            meta_q     <= bus.meta;
                            scan_n_q   <= bus.scan_edges;
                            scan_cnt_q <= '0;
                            sync_cnt_q <= SYNC_CNT_W'(1);
                            idx_q      <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (fire) begin
                            sync_cnt_q <= sync_cnt_q + 1'b1;
                            if (sync_cnt_q == SYNC_CNT_W'(NUM_SYNC_EDGES - 1)) begin
                                state_q <= START;
                            end
                        end
                    end
                    START: begin
                        if (fire) begin
                            idx_q   <= '0;
                            state_q <= BIT_A;
                        end
                    end
                    BIT_A: begin
                        if (fire) begin
                            state_q <= BIT_B;
                        end
                    end
                    BIT_B: begin
                        if (fire) begin
                            if (idx_q == META_IDX_W'(META_BITS - 1)) begin
                                state_q <= SCAN_WAIT;
                            end else begin
                                idx_q   <= idx_nxt;
                                state_q <= BIT_A;
                            end
                        end
                    end
                    SCAN_WAIT: begin
                        if (scan_n_q == '0) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            scan_pos_q <= 1'b0;
                            data_q     <= 1'b0;
                        end else if (fire) begin
                            scan_cnt_q <= 8'd1;
                            scan_pos_q <= 1'b1;
                            state_q    <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (scan_cnt_q == scan_n_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            scan_pos_q <= 1'b0;
                            data_q     <= 1'b0;
                        end else if (fire) begin
                            scan_cnt_q <= scan_cnt_q + 1'b1;
                            scan_pos_q <= ~scan_pos_q;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.DATA_OUT    = data_q;
    assign bus.edge_strobe = strobe_q;
    assign bus.scan_pos    = scan_pos_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state_q;

endmodule
